uart_status_flags: RTL and testbench

//  Parametrised bank of WIDTH set/reset status flags for the UART (RX ready, TX empty, framing, parity, ...).
//  Per-bit set/clear with selectable priority, optional rising-edge set detection, write-1-to-clear host access,

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_flag_cell.sv | 77 +++++++
 rtl/uart_status_flags.sv | 100 ++++++++++
 tb/tb_uart_status_flags.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART status-flag bank: default widths, the
// conventional flag bit positions, and the set/reset priority resolver
// used by every flag cell.
// Optional feature macro: UART_FLAG_OVR_CNT_EN (overrun event counter).
package uart_pkg;

  // Default bank geometry.
  localparam int UART_FLAG_WIDTH = 8;
  localparam int UART_OVR_CNT_W  = 8;

  // Conventional UART flag bit positions within the bank.
  localparam int FLG_RXRDY  = 0;  // receive data ready
  localparam int FLG_TXEMP  = 1;  // transmit holding register empty
  localparam int FLG_FERR   = 2;  // framing error
  localparam int FLG_PERR   = 3;  // parity error
  localparam int FLG_RXOVR  = 4;  // receive FIFO overflow
  localparam int FLG_BRK    = 5;  // break detected
  localparam int FLG_TXDONE = 6;  // transmit shift register drained
  localparam int FLG_RXTO   = 7;  // receive timeout

  // Action a flag takes on the coming clock edge.
  typedef enum logic [1:0] {
    SR_HOLD = 2'd0,
    SR_SET  = 2'd1,
    SR_CLR  = 2'd2
  } sr_action_e;

  // Resolves simultaneous set and clear requests; set_dom picks the winner.
  function automatic sr_action_e sr_resolve(input logic set_ev,
                                            input logic clr_ev,
                                            input bit   set_dom);
    sr_action_e act;
    if (set_ev && clr_ev) begin
      act = set_dom ? SR_SET : SR_CLR;
    end else if (set_ev) begin
      act = SR_SET;
    end else if (clr_ev) begin
      act = SR_CLR;
    end else begin
      act = SR_HOLD;
    end
    return act;
  endfunction

endpackage

// File: rtl/uart_flag_cell.sv
// One status-flag bit: optional rising-edge set detection, priority
// set/reset flop and sticky overrun flag. Host write-1-to-clear acts as an
// additional clear source for the flag and is the only clear for overrun.
// Optional feature macro: UART_FLAG_OVR_CNT_EN exposes the per-cycle overrun
// event so the parent can count it.
module uart_flag_cell
  import uart_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b0,  // 1: set on rising edge of set; 0: level
  parameter bit SET_DOM   = 1'b1   // 1: set beats clear in the same cycle
) (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  input  logic w1c,
  output logic q,
  output logic ovr
`ifdef UART_FLAG_OVR_CNT_EN
  ,
  output logic ovr_ev
`endif
);

  logic       set_d;
  logic       set_ev;
  logic       clr_ev;
  logic       ovr_hit;
  logic       q_next;
  sr_action_e action;

  // In edge mode a level held high produces exactly one set event.
  assign set_ev  = EDGE_MODE ? (set & ~set_d) : set;
  assign clr_ev  = clr | w1c;

  // A set arriving on an already-set flag is lost information, unless the
  // same cycle also clears the flag (the new event then restarts it).
  assign ovr_hit = set_ev & q & ~clr_ev;

  assign action  = sr_resolve(set_ev, clr_ev, SET_DOM);

`ifdef UART_FLAG_OVR_CNT_EN
  assign ovr_ev = ovr_hit;
`endif

  // Next flag value from the resolved set/clear action.
  always_comb begin
    // NOTE: q_next gets a default before the case so no path leaves it unassigned, which would infer a latch.
    q_next = q;
    case (action)
      SR_SET:  q_next = 1'b1;
      SR_CLR:  q_next = 1'b0;
      default: q_next = q;
    endcase
  end

  // Flag, overrun and edge-history registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: reset is asynchronous, so it sits in the sensitivity list and is tested first.
    if (reset) begin
      q     <= 1'b0;
      ovr   <= 1'b0;
      set_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
      q     <= q_next;
      set_d <= set;
      // A new overrun outranks a host clear so the event is never dropped.
      if (ovr_hit) begin
        ovr <= 1'b1;
      end else if (w1c) begin
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_status_flags.sv
// Bank of WIDTH UART status flags between the UART datapath and the host
// register block: per-bit flag cells, interrupt mask register, registered
// interrupt output and, optionally, a saturating overrun event counter.
// Optional feature macro: UART_FLAG_OVR_CNT_EN adds ovr_cnt / ovr_cnt_clr.
module uart_status_flags
  import uart_pkg::*;
#(
  parameter int               WIDTH    = UART_FLAG_WIDTH,
  parameter bit               SET_DOM  = 1'b1,
  parameter logic [WIDTH-1:0] EDGE_SET = '0,
  parameter logic [WIDTH-1:0] MASK_RST = '0,
  parameter int               CNT_W    = UART_OVR_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  input  logic             w1c_we,
  input  logic [WIDTH-1:0] w1c_data,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_wd,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] ovr,
  output logic [WIDTH-1:0] mask_q,
  output logic             irq
`ifdef UART_FLAG_OVR_CNT_EN
  ,
  output logic [CNT_W-1:0] ovr_cnt,
  input  logic             ovr_cnt_clr
`endif
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("uart_status_flags: WIDTH must be in 1..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("uart_status_flags: CNT_W must be at least 1");
  end

  // Host write-1-to-clear, qualified by its strobe.
  logic [WIDTH-1:0] w1c_bits;
  assign w1c_bits = w1c_we ? w1c_data : '0;

`ifdef UART_FLAG_OVR_CNT_EN
  logic [WIDTH-1:0] ovr_ev;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    uart_flag_cell #(
      .EDGE_MODE (EDGE_SET[i]),
      .SET_DOM   (SET_DOM)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .set    (set[i]),
      .clr    (clr[i]),
      .w1c    (w1c_bits[i]),
      .q      (q[i]),
      .ovr    (ovr[i])
`ifdef UART_FLAG_OVR_CNT_EN
      ,
      .ovr_ev (ovr_ev[i])
`endif
    );
  end

  // Interrupt mask register, written whole by the host.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= MASK_RST;
    end else if (mask_we) begin
      mask_q <= mask_wd;
    end
  end

  // Interrupt is a registered copy of the masked flag state, so it follows a
  // flag or mask change by one cycle and has no combinational path from set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(q & mask_q);
    end
  end

`ifdef UART_FLAG_OVR_CNT_EN
  // Counts cycles with at least one new overrun; saturates, clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_cnt <= '0;
    end else if (ovr_cnt_clr) begin
      ovr_cnt <= '0;
    end else if ((|ovr_ev) && (ovr_cnt != {CNT_W{1'b1}})) begin
      ovr_cnt <= ovr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_status_flags.sv
// Self-checking bench for uart_status_flags. Two instances share stimulus:
// instance 0 is set-dominant with bit 1 in edge mode, instance 1 is
// clear-dominant and all-level. Both are compared every cycle against a
// behavioural model built from the flag rules, plus directed expectations.
// Optional feature macro: UART_FLAG_OVR_CNT_EN (counter checks, CNT_W=2).
module tb_uart_status_flags;

  localparam logic [7:0] MASK_RST = 8'hA5;
  localparam int         CNT_MAX  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] set, clr, w1c_data, mask_wd;
  logic       w1c_we, mask_we;

  logic [7:0] obs_q[2], obs_ovr[2], obs_mask[2];
  logic       obs_irq[2];

  int checks = 0;
  int errors = 0;

  // Reference model state, per instance.
  bit         m_sdom[2] = '{1'b1, 1'b0};
  logic [7:0] m_edge[2] = '{8'h02, 8'h00};
  logic [7:0] m_q[2], m_ovr[2], m_mask[2], m_setd[2];
  logic       m_irq[2];

`ifdef UART_FLAG_OVR_CNT_EN
  logic       ovr_cnt_clr;
  logic [1:0] obs_cnt[2];
  int         m_cnt[2];
`endif

  uart_status_flags #(
    .WIDTH(8), .SET_DOM(1'b1), .EDGE_SET(8'h02), .MASK_RST(MASK_RST), .CNT_W(2)
  ) dut_a (
    .clk(clk), .reset(reset), .set(set), .clr(clr),
    .w1c_we(w1c_we), .w1c_data(w1c_data), .mask_we(mask_we), .mask_wd(mask_wd),
    .q(obs_q[0]), .ovr(obs_ovr[0]), .mask_q(obs_mask[0]), .irq(obs_irq[0])
`ifdef UART_FLAG_OVR_CNT_EN
    , .ovr_cnt(obs_cnt[0]), .ovr_cnt_clr(ovr_cnt_clr)
`endif
  );

  uart_status_flags #(
    .WIDTH(8), .SET_DOM(1'b0), .EDGE_SET(8'h00), .MASK_RST(MASK_RST), .CNT_W(2)
  ) dut_b (
    .clk(clk), .reset(reset), .set(set), .clr(clr),
    .w1c_we(w1c_we), .w1c_data(w1c_data), .mask_we(mask_we), .mask_wd(mask_wd),
    .q(obs_q[1]), .ovr(obs_ovr[1]), .mask_q(obs_mask[1]), .irq(obs_irq[1])
`ifdef UART_FLAG_OVR_CNT_EN
    , .ovr_cnt(obs_cnt[1]), .ovr_cnt_clr(ovr_cnt_clr)
`endif
  );

  task automatic idle();
    set = '0; clr = '0; w1c_we = 1'b0; w1c_data = '0;
    mask_we = 1'b0; mask_wd = '0;
`ifdef UART_FLAG_OVR_CNT_EN
    ovr_cnt_clr = 1'b0;
`endif
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = '0; m_ovr[k] = '0; m_mask[k] = MASK_RST; m_setd[k] = '0; m_irq[k] = 1'b0;
`ifdef UART_FLAG_OVR_CNT_EN
      m_cnt[k] = 0;
`endif
    end
  endtask

  // One clock edge of the reference model, using the inputs seen at the edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] nq, novr;
      bit any_ovr;
      nq = m_q[k]; novr = m_ovr[k]; any_ovr = 0;
      for (int i = 0; i < 8; i++) begin
        bit sev, cev, hit;
        sev = m_edge[k][i] ? (set[i] && !m_setd[k][i]) : set[i];
        cev = clr[i] || (w1c_we && w1c_data[i]);
        if (sev && cev)  nq[i] = m_sdom[k];
        else if (sev)    nq[i] = 1'b1;
        else if (cev)    nq[i] = 1'b0;
        hit = sev && m_q[k][i] && !cev;
        if (w1c_we && w1c_data[i]) novr[i] = 1'b0;
        if (hit) begin
          novr[i] = 1'b1;
          any_ovr = 1;
        end
      end
      m_irq[k] = |(m_q[k] & m_mask[k]);
      if (mask_we) m_mask[k] = mask_wd;
      m_q[k] = nq; m_ovr[k] = novr; m_setd[k] = set;
`ifdef UART_FLAG_OVR_CNT_EN
      if (ovr_cnt_clr)                      m_cnt[k] = 0;
      else if (any_ovr && m_cnt[k] < CNT_MAX) m_cnt[k] = m_cnt[k] + 1;
`endif
    end
  endtask

  // Scoreboard comparison of every output of both instances against the model.
  task automatic compare_model(input string tag);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q[k] !== m_q[k]) begin
        errors++; $display("FAIL %s inst%0d q got %h want %h", tag, k, obs_q[k], m_q[k]);
      end
      checks++;
      if (obs_ovr[k] !== m_ovr[k]) begin
        errors++; $display("FAIL %s inst%0d ovr got %h want %h", tag, k, obs_ovr[k], m_ovr[k]);
      end
      checks++;
      if (obs_mask[k] !== m_mask[k]) begin
        errors++; $display("FAIL %s inst%0d mask_q got %h want %h", tag, k, obs_mask[k], m_mask[k]);
      end
      checks++;
      if (obs_irq[k] !== m_irq[k]) begin
        errors++; $display("FAIL %s inst%0d irq got %b want %b", tag, k, obs_irq[k], m_irq[k]);
      end
`ifdef UART_FLAG_OVR_CNT_EN
      checks++;
      if (obs_cnt[k] !== 2'(m_cnt[k])) begin
        errors++; $display("FAIL %s inst%0d ovr_cnt got %0d want %0d", tag, k, obs_cnt[k], m_cnt[k]);
      end
`endif
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q[k] !== 8'h00 || obs_ovr[k] !== 8'h00 || obs_mask[k] !== MASK_RST || obs_irq[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d q/ovr/mask/irq got %h/%h/%h/%b want 00/00/%h/0",
                 k, obs_q[k], obs_ovr[k], obs_mask[k], obs_irq[k], MASK_RST);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step("reset_idle");
  endtask

  task automatic test_level_set();
    idle(); mask_we = 1'b1; mask_wd = 8'h01;
    step("level_mask");
    idle(); set = 8'h01;
    step("level_set");
    checks++;
    if (obs_q[0] !== 8'h01 || obs_irq[0] !== 1'b0) begin
      errors++; $display("FAIL level_set q/irq got %h/%b want 01/0", obs_q[0], obs_irq[0]);
    end
    idle();
    step("level_irq");
    checks++;
    if (obs_irq[0] !== 1'b1) begin
      errors++; $display("FAIL level_irq irq got %b want 1", obs_irq[0]);
    end
  endtask

  task automatic test_priority();
    idle(); set = 8'h01;
    step("prio_pre");
    idle(); set = 8'h01; clr = 8'h01;
    step("prio");
    checks++;
    if (obs_q[0][0] !== 1'b1 || obs_q[1][0] !== 1'b0) begin
      errors++;
      $display("FAIL priority q[0] set_dom/clr_dom got %b/%b want 1/0", obs_q[0][0], obs_q[1][0]);
    end
    idle();
    step("prio_post");
  endtask

  task automatic test_edge();
    idle(); set = 8'h02;
    step("edge_first");
    checks++;
    if (obs_q[0][1] !== 1'b1) begin
      errors++; $display("FAIL edge_first q[1] got %b want 1", obs_q[0][1]);
    end
    w1c_we = 1'b1; w1c_data = 8'h02;
    step("edge_w1c");
    w1c_we = 1'b0; w1c_data = '0;
    for (int n = 0; n < 5; n++) begin
      step("edge_hold");
      checks++;
      if (obs_q[0][1] !== 1'b0) begin
        errors++; $display("FAIL edge_hold cycle %0d q[1] got %b want 0", n, obs_q[0][1]);
      end
    end
    set = 8'h00;
    step("edge_low");
    set = 8'h02;
    step("edge_rise");
    checks++;
    if (obs_q[0][1] !== 1'b1) begin
      errors++; $display("FAIL edge_rise q[1] got %b want 1", obs_q[0][1]);
    end
    idle();
    step("edge_post");
  endtask

  task automatic test_overrun();
    idle(); w1c_we = 1'b1; w1c_data = 8'hFF;
`ifdef UART_FLAG_OVR_CNT_EN
    ovr_cnt_clr = 1'b1;
`endif
    step("ovr_clear_all");
    idle(); set = 8'h04;
    step("ovr_set");
    idle();
    step("ovr_gap");
    set = 8'h04;
    step("ovr_hit");
    checks++;
    if (obs_ovr[0] !== 8'h04 || obs_ovr[1] !== 8'h04) begin
      errors++; $display("FAIL ovr_hit ovr got %h/%h want 04/04", obs_ovr[0], obs_ovr[1]);
    end
    idle(); w1c_we = 1'b1; w1c_data = 8'h04;
    step("ovr_w1c");
    checks++;
    if (obs_q[0][2] !== 1'b0 || obs_ovr[0][2] !== 1'b0) begin
      errors++; $display("FAIL ovr_w1c q[2]/ovr[2] got %b/%b want 0/0", obs_q[0][2], obs_ovr[0][2]);
    end
`ifdef UART_FLAG_OVR_CNT_EN
    checks++;
    if (obs_cnt[0] !== 2'd1) begin
      errors++; $display("FAIL ovr_cnt_one got %0d want 1", obs_cnt[0]);
    end
`endif
    idle();
    step("ovr_post");
  endtask

`ifdef UART_FLAG_OVR_CNT_EN
  task automatic test_cnt_sat();
    idle(); ovr_cnt_clr = 1'b1;
    step("cnt_clr");
    idle(); set = 8'h04;
    step("cnt_arm");
    for (int n = 0; n < 5; n++) step("cnt_run");
    checks++;
    if (obs_cnt[0] !== 2'd3) begin
      errors++; $display("FAIL cnt_sat got %0d want 3", obs_cnt[0]);
    end
    ovr_cnt_clr = 1'b1;
    step("cnt_clr_wins");
    checks++;
    if (obs_cnt[0] !== 2'd0) begin
      errors++; $display("FAIL cnt_clr_wins got %0d want 0", obs_cnt[0]);
    end
    idle();
    step("cnt_post");
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set      = 8'($urandom);
      clr      = 8'($urandom) & 8'($urandom);
      w1c_we   = ($urandom_range(0, 3) == 0);
      w1c_data = 8'($urandom);
      mask_we  = ($urandom_range(0, 7) == 0);
      mask_wd  = 8'($urandom);
`ifdef UART_FLAG_OVR_CNT_EN
      ovr_cnt_clr = ($urandom_range(0, 15) == 0);
`endif
      step("random");
    end
    idle();
    step("random_post");
  endtask

  task automatic test_async_reset();
    idle(); w1c_we = 1'b1; w1c_data = 8'hFF;
    step("ar_clear");
    idle(); set = 8'hFF; mask_we = 1'b1; mask_wd = 8'hFF;
    step("ar_fill");
    idle();
    step("ar_irq");
    checks++;
    if (obs_q[0] !== 8'hFF || obs_mask[0] !== 8'hFF || obs_irq[0] !== 1'b1) begin
      errors++; $display("FAIL ar_fill q/mask/irq got %h/%h/%b want ff/ff/1", obs_q[0], obs_mask[0], obs_irq[0]);
    end
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q[k] !== 8'h00 || obs_ovr[k] !== 8'h00 || obs_mask[k] !== MASK_RST || obs_irq[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset inst%0d q/ovr/mask/irq got %h/%h/%h/%b want 00/00/%h/0",
                 k, obs_q[k], obs_ovr[k], obs_mask[k], obs_irq[k], MASK_RST);
      end
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step("ar_after");
  endtask

  initial begin
    reset = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_level_set();
    test_priority();
    test_edge();
    test_overrun();
`ifdef UART_FLAG_OVR_CNT_EN
    test_cnt_sat();
`endif
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
